// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the button-guessing game round sequencer.
//   game_state_t       : controller state encoding
//   SCORE_MAX          : score saturation value
//   LEVEL_MAX          : difficulty level saturation value
//   DEFAULT_LIVES      : lives at game start when not overridden
//   DEFAULT_HOLD_TICKS : prescaler ticks the round result is held
//   calc_reload()      : prescaler reload value for a given difficulty level
// ---------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        PLAY,
        RESULT,
        OVER
    } game_state_t;

    localparam logic [3:0] SCORE_MAX          = 4'd15;
    localparam logic [2:0] LEVEL_MAX          = 3'd7;
    localparam int         DEFAULT_LIVES      = 3;
    localparam int         DEFAULT_HOLD_TICKS = 4;

    // Each level halves the full-scale count, but the reload never drops
    // below 1 so the fastest tick period is two cycles.
    function automatic logic [31:0] calc_reload(input int width, input logic [2:0] lvl);
        logic [31:0] full;
        logic [31:0] shifted;
        full    = (32'd1 << width) - 32'd1;
        shifted = full >> lvl;
        if (shifted == 32'd0) begin
            shifted = 32'd1;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/guess_game_ctrl_if.sv
// ---------------------------------------------------------------------------
// guess_game_ctrl_if
// Signal bundle between the board-level logic / guess FSM and the round
// sequencer.
//   start     : single-cycle start pulse (board -> controller)
//   win_in    : win flag from the guess FSM
//   lose_in   : lose flag from the guess FSM
//   guess_en  : one-cycle pacing tick to the guess FSM
//   guess_rst : active-high reset to the guess FSM
//   score     : wins this game (saturating)
//   lives     : remaining lives
//   level     : difficulty level (saturating)
//   game_over : high while the game is over
//   busy      : high while a round is in progress
// Modports: master = board / guess FSM side, slave = controller.
// ---------------------------------------------------------------------------
interface guess_game_ctrl_if;

    logic       start;
    logic       win_in;
    logic       lose_in;
    logic       guess_en;
    logic       guess_rst;
    logic [3:0] score;
    logic [1:0] lives;
    logic [2:0] level;
    logic       game_over;
    logic       busy;

    modport master (
        output start, win_in, lose_in,
        input  guess_en, guess_rst, score, lives, level, game_over, busy
    );

    modport slave (
        input  start, win_in, lose_in,
        output guess_en, guess_rst, score, lives, level, game_over, busy
    );

endinterface

// File: rtl/guess_game_ctrl_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// N-bit down-counting prescaler producing the game pacing tick.
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   load     : load strobe, counter takes load_val
//   load_val : reload value (tick period is load_val + 1 cycles)
//   run      : count enable
//   wrap     : counter is at zero and will reload on this edge
//   tick     : registered one-cycle tick, high the cycle after a wrap
// ---------------------------------------------------------------------------
module tick_gen #(
    parameter int N = 21
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         run,
    output logic         wrap,
    output logic         tick
);

    logic [N-1:0] cnt;

    // A load always wins over a wrap so a fresh period starts cleanly.
    assign wrap = run && !load && (cnt == '0);

    // Counter register: load has priority, a wrap reloads, otherwise count
    // down while running. The tick flop simply registers the wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '1;
            tick <= 1'b0;
        end else begin
            tick <= wrap;
            if (load || wrap) begin
                cnt <= load_val;
            end else if (run) begin
                cnt <= cnt - N'(1);
            end
        end
    end

endmodule

// File: rtl/guess_game_ctrl.sv
// ---------------------------------------------------------------------------
// guess_game_ctrl
// Round sequencer for the button-guessing game. Paces the guess FSM with a
// tick whose period shrinks with each win, resets the FSM between rounds,
// and keeps score, lives and difficulty level.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : guess_game_ctrl_if.slave (start, win_in, lose_in in;
//         guess_en, guess_rst, score, lives, level, game_over, busy out)
// Parameters: N (prescaler width), LIVES (1..3), HOLD_TICKS (1..15).
// ---------------------------------------------------------------------------
module guess_game_ctrl
    import game_pkg::*;
#(
    parameter int N          = 21,
    parameter int LIVES      = DEFAULT_LIVES,
    parameter int HOLD_TICKS = DEFAULT_HOLD_TICKS
) (
    input  logic              clk,
    input  logic              rst,
    guess_game_ctrl_if.slave  bus
);

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [3:0] HOLD_LAST  = 4'(HOLD_TICKS - 1);

    game_state_t  state_q, state_d;
    logic [3:0]   score_q, score_d;
    logic [1:0]   lives_q, lives_d;
    logic [2:0]   level_q, level_d;
    logic [3:0]   hold_q,  hold_d;
    logic         guess_rst_q;
    logic         busy_q;
    logic         game_over_q;

    logic         load;
    logic         run;
    logic         wrap;
    logic         tick;
    logic [N-1:0] reload_val;

    // The prescaler runs in PLAY and RESULT. It is reloaded in ARM and on the
    // outcome edge, the latter so the result hold is timed at the new level.
    assign run  = (state_q == PLAY) || (state_q == RESULT);
    assign load = (state_q == ARM) ||
                  ((state_q == PLAY) && (bus.win_in || bus.lose_in));

    // Reload follows the next level so an outcome edge loads the new period.
    assign reload_val = N'(calc_reload(N, level_d));

    tick_gen #(
        .N (N)
    ) u_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (reload_val),
        .run      (run),
        .wrap     (wrap),
        .tick     (tick)
    );

    // Next-state and counter logic. Outcome flags only matter in PLAY, with
    // lose taking priority; start only matters in IDLE and OVER. RESULT
    // counts prescaler wraps and re-arms after HOLD_TICKS of them.
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        lives_d = lives_q;
        level_d = level_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE, OVER: begin
                if (bus.start) begin
                    state_d = ARM;
                    score_d = '0;
                    lives_d = LIVES_INIT;
                    level_d = '0;
                end
            end
            ARM: begin
                state_d = PLAY;
            end
            PLAY: begin
                if (bus.lose_in) begin
                    lives_d = lives_q - 2'd1;
                    hold_d  = '0;
                    state_d = (lives_d == 2'd0) ? OVER : RESULT;
                end else if (bus.win_in) begin
                    if (score_q != SCORE_MAX) begin
                        score_d = score_q + 4'd1;
                    end
                    if (level_q != LEVEL_MAX) begin
                        level_d = level_q + 3'd1;
                    end
                    hold_d  = '0;
                    state_d = RESULT;
                end
            end
            RESULT: begin
                if (wrap) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = ARM;
                    end else begin
                        hold_d = hold_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and the registered status outputs. The status flops
    // are computed from the next state so they line up with the state
    // register and never see the inputs combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            score_q     <= '0;
            lives_q     <= LIVES_INIT;
            level_q     <= '0;
            hold_q      <= '0;
            guess_rst_q <= 1'b1;
            busy_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            level_q     <= level_d;
            hold_q      <= hold_d;
            guess_rst_q <= (state_d == IDLE) || (state_d == ARM) || (state_d == OVER);
            busy_q      <= (state_d == ARM) || (state_d == PLAY) || (state_d == RESULT);
            game_over_q <= (state_d == OVER);
        end
    end

    // The tick only reaches the guess FSM in PLAY; in RESULT it merely
    // times the hold.
    assign bus.guess_en  = tick && (state_q == PLAY);
    assign bus.guess_rst = guess_rst_q;
    assign bus.score     = score_q;
    assign bus.lives     = lives_q;
    assign bus.level     = level_q;
    assign bus.game_over = game_over_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_guess_game_ctrl
// Directed self-checking bench for guess_game_ctrl with N=4, LIVES=3,
// HOLD_TICKS=2. Inputs change and outputs are sampled on falling edges.
// ---------------------------------------------------------------------------
module tb_guess_game_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    guess_game_ctrl_if bus ();

    guess_game_ctrl #(
        .N          (4),
        .LIVES      (3),
        .HOLD_TICKS (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something stalls beyond all cycle budgets.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected tick reload for a 4-bit prescaler at a given level.
    function automatic int reloadOf(input int lvl);
        int r;
        r = 15 >> lvl;
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive the inputs across exactly one rising edge, returning on the
    // falling edge after it.
    task automatic applyStimulus(input logic s, input logic w, input logic l);
        bus.start   = s;
        bus.win_in  = w;
        bus.lose_in = l;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.win_in  = 1'b0;
        bus.lose_in = 1'b0;
    endtask

    // Cycles until the next guess_en, bounded.
    task automatic waitTick(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.guess_en && cyc < 100);
    endtask

    // Cycles until guess_rst rises (end of RESULT), counting any guess_en.
    task automatic waitRst(output int cyc, output int en_seen);
        cyc     = 0;
        en_seen = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (bus.guess_en) en_seen++;
        end while (!bus.guess_rst && cyc < 200);
    endtask

    initial begin
        int cyc;
        int en_seen;
        int exp_score;
        int exp_level;

        checks      = 0;
        failures    = 0;
        rst         = 1'b0;
        bus.start   = 1'b0;
        bus.win_in  = 1'b0;
        bus.lose_in = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("rst_guess_rst", bus.guess_rst, 1);
        checkOutput("rst_guess_en",  bus.guess_en,  0);
        checkOutput("rst_score",     bus.score,     0);
        checkOutput("rst_lives",     bus.lives,     3);
        checkOutput("rst_level",     bus.level,     0);
        checkOutput("rst_game_over", bus.game_over, 0);
        checkOutput("rst_busy",      bus.busy,      0);
        rst = 1'b1;
        @(negedge clk);

        // Start and tick pacing at level 0
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("arm_busy",      bus.busy,      1);
        checkOutput("arm_guess_rst", bus.guess_rst, 1);
        @(negedge clk);
        checkOutput("play_guess_rst", bus.guess_rst, 0);
        waitTick(cyc);
        checkOutput("lvl0_first_tick", cyc, 16);
        waitTick(cyc);
        checkOutput("lvl0_second_tick", cyc, 16);

        // Asynchronous reset mid-PLAY
        #3;
        rst = 1'b0;
        #1;
        checkOutput("async_guess_rst", bus.guess_rst, 1);
        checkOutput("async_guess_en",  bus.guess_en,  0);
        checkOutput("async_busy",      bus.busy,      0);
        checkOutput("async_lives",     bus.lives,     3);
        @(negedge clk);
        rst = 1'b1;
        en_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.guess_en) en_seen++;
        end
        checkOutput("idle_no_tick", en_seen, 0);
        checkOutput("idle_guess_rst", bus.guess_rst, 1);

        // Win handling
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        waitTick(cyc);
        checkOutput("restart_first_tick", cyc, 16);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("win_score",     bus.score,     1);
        checkOutput("win_level",     bus.level,     1);
        checkOutput("win_lives",     bus.lives,     3);
        checkOutput("win_busy",      bus.busy,      1);
        checkOutput("win_guess_rst", bus.guess_rst, 0);
        checkOutput("win_guess_en",  bus.guess_en,  0);
        // start and win during RESULT must be ignored
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("result_ign_score", bus.score, 1);
        checkOutput("result_ign_level", bus.level, 1);
        waitRst(cyc, en_seen);
        checkOutput("win_hold_len",   cyc + 1, 16);
        checkOutput("win_hold_no_en", en_seen, 0);
        @(negedge clk);
        checkOutput("lvl1_play_guess_rst", bus.guess_rst, 0);
        waitTick(cyc);
        checkOutput("lvl1_first_tick", cyc, 8);
        waitTick(cyc);
        checkOutput("lvl1_second_tick", cyc, 8);

        // Losses, including simultaneous win and lose
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("lose1_lives", bus.lives, 2);
        checkOutput("lose1_score", bus.score, 1);
        checkOutput("lose1_busy",  bus.busy,  1);
        waitRst(cyc, en_seen);
        checkOutput("lose1_hold_len", cyc, 16);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("both_lives", bus.lives, 1);
        checkOutput("both_score", bus.score, 1);
        checkOutput("both_level", bus.level, 1);
        waitRst(cyc, en_seen);
        checkOutput("both_hold_len", cyc, 16);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("lose3_lives",     bus.lives,     0);
        checkOutput("lose3_game_over", bus.game_over, 1);
        checkOutput("lose3_busy",      bus.busy,      0);
        checkOutput("lose3_guess_rst", bus.guess_rst, 1);
        checkOutput("lose3_guess_en",  bus.guess_en,  0);
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("over_win_ign_score", bus.score,     1);
        checkOutput("over_hold",          bus.game_over, 1);

        // Restart from OVER
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("restart_lives",     bus.lives,     3);
        checkOutput("restart_score",     bus.score,     0);
        checkOutput("restart_level",     bus.level,     0);
        checkOutput("restart_game_over", bus.game_over, 0);
        checkOutput("restart_guess_rst", bus.guess_rst, 1);
        @(negedge clk);

        // Sixteen wins: score and level saturate, hold shrinks with level
        for (int i = 0; i < 16; i++) begin
            exp_score = (i + 1 > 15) ? 15 : i + 1;
            exp_level = (i + 1 > 7) ? 7 : i + 1;
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("sat_score_%0d", i), bus.score, exp_score);
            checkOutput($sformatf("sat_level_%0d", i), bus.level, exp_level);
            waitRst(cyc, en_seen);
            checkOutput($sformatf("sat_hold_%0d", i), cyc, 2 * (reloadOf(exp_level) + 1));
            @(negedge clk);
        end
        waitTick(cyc);
        checkOutput("lvl7_first_tick", cyc, 2);
        waitTick(cyc);
        checkOutput("lvl7_second_tick", cyc, 2);
        checkOutput("lvl7_lives", bus.lives, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/guess_game_ctrl.md
# guess_game_ctrl

Round sequencer for the button-guessing game. It generates the enable tick that paces the guess FSM and pulses the FSM's reset between rounds. It also scores win/lose outcomes, tracks remaining lives and raises difficulty by shortening the tick period after each win. It sits between the board-level start button/display logic and one guess FSM instance.

## Interface
- N, 21: prescaler width; level-0 tick period is 2^N cycles
- LIVES, 3: lives at game start (1..3)
- HOLD_TICKS, 4: ticks the result is held before the next round (1..15)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle start pulse, already synchronized and debounced
- win_in  in  1  win flag from guess FSM
- lose_in  in  1  lose flag from guess FSM
- guess_en  out  1  one-cycle tick to guess FSM `en`
- guess_rst  out  1  active-high reset to guess FSM
- score  out  4  wins this game, saturating
- lives  out  2  remaining lives
- level  out  3  difficulty level, saturating at 7
- game_over  out  1  high in OVER
- busy  out  1  high in ARM, PLAY, RESULT

## Operation
- States: IDLE, ARM, PLAY, RESULT, OVER.
- Reset values:
  - state IDLE; score 0; lives LIVES; level 0
  - guess_en 0; guess_rst 1; game_over 0; busy 0
  - prescaler all ones
- IDLE:
  - guess_rst = 1.
  - start → ARM; score, lives and level reload to 0, LIVES and 0.
- ARM (one cycle):
  - guess_rst = 1.
  - Prescaler loads reload(level).
  - → PLAY.
- PLAY:
  - guess_rst = 0.
  - Prescaler decrements each cycle. On reaching 0 it reloads and guess_en pulses for 1 cycle.
- reload(level) = max(1, (2^N − 1) >> level), giving a tick period of reload + 1 cycles.
- Outcome handling in PLAY:
  - win_in and lose_in are sampled only in PLAY; ignored in every other state.
  - lose_in (priority when both are high): lives − 1. → OVER if the new value is 0, else → RESULT.
  - win_in: score + 1, saturating at 15; level + 1, saturating at 7. → RESULT.
- RESULT:
  - guess_rst = 0 and guess_en = 0. The guess FSM is frozen so its outcome display holds.
  - The prescaler keeps running; its internal ticks are counted.
  - After HOLD_TICKS internal ticks → ARM.
- OVER:
  - game_over = 1; guess_rst = 1.
  - start → ARM with full reload of score, lives and level.
- start is ignored in ARM, PLAY and RESULT.
- Counter updates (score, lives, level) take effect on the same edge as the state change.

## Timing
- start high at edge t (IDLE or OVER):
  - ARM visible after t; guess_rst high for that one cycle.
  - PLAY after t+1.
- First guess_en asserts reload + 1 cycles after PLAY entry. Subsequent ticks are every reload + 1 cycles.
- win_in/lose_in sampled at edge t in PLAY:
  - New score, lives and level visible after t.
  - State is RESULT or OVER after t; guess_en is 0 from then.
- A tick coinciding with an outcome edge is suppressed.
- RESULT lasts HOLD_TICKS × (reload + 1) cycles, using reload at the already-incremented level.
- Reset assertion in any state takes effect immediately (asynchronous). All outputs go to their reset values; guess_rst = 1 holds the guess FSM in reset.
- All outputs are registered. guess_en and guess_rst have no combinational path from inputs.

## Structure
- Package game_pkg:
  - state enum type game_state_t (IDLE, ARM, PLAY, RESULT, OVER)
  - score/level saturation constants (15, 7)
  - default LIVES and HOLD_TICKS
- Sub-module tick_gen: N-bit down-counter.
  - Inputs: load strobe, load value, run enable.
  - Output: registered one-cycle tick.
  - Instantiated once; the controller gates its tick onto guess_en only in PLAY.

## Test plan
Benches use N=4, LIVES=3, HOLD_TICKS=2.
- Reset mid-PLAY:
  - Stimulus: rst low.
  - Response: immediately guess_rst = 1, guess_en = 0, score = 0, lives = 3, level = 0, state IDLE; no tick after rst is released until start.
- Start, then tick pacing:
  - Stimulus: start pulse.
  - Response: guess_rst high exactly 1 cycle. First guess_en 16 cycles after PLAY entry, then every 16 cycles. busy = 1.
- Win handling:
  - Stimulus: win_in in PLAY.
  - Response: next cycle score = 1, level = 1, state RESULT.
  - guess_en stays 0 for 2 × 8 = 16 cycles.
  - Then ARM, then PLAY with a tick every 8 cycles.
- Three losses:
  - Stimulus: three lose_in outcomes.
  - Response: lives 2 → 1 → 0. After the third: game_over = 1, busy = 0, guess_rst = 1.
  - start then restores lives = 3, score = 0.
- Simultaneous flags:
  - Stimulus: win_in and lose_in high on the same edge.
  - Response: lives decrements; score and level unchanged.
- Saturation and ignored inputs:
  - 16 wins → score = 15, level = 7, tick every 2 cycles (reload floor 1).
  - start and win_in asserted during RESULT → no effect.
